// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the LDPC layered-decoding scheduler:
// FSM state encoding, default null-circulant value and a safe width helper.
package ldpc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StLayerWait,
        StIterEnd,
        StDone
    } sched_state_e;

    localparam int unsigned LDPC_DATA_W = 8;
    localparam logic [LDPC_DATA_W-1:0] NULL_SHIFT = '1;

    // Width of a counter/index covering 0..n-1; never narrower than one bit.
    function automatic int unsigned width_of(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ldpc_layer_sched.sv
// Layered LDPC scheduler: walks the base matrix layer by layer, issues one {shift,row,col}
// command per entry and iterates until syndrome_ok or MAX_ITER. Optional macro: SKIP_NULL_EN.
module ldpc_layer_sched
    import ldpc_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned D        = 5,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 8,
    parameter int unsigned MAX_ITER = 10,
    localparam int unsigned AW = width_of(ROWS * COLS),
    localparam int unsigned RW = width_of(ROWS),
    localparam int unsigned CW = width_of(COLS),
    localparam int unsigned IW = width_of(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [AW-1:0]     bm_addr,
    input  logic [DATA_W-1:0] bm_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_shift,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    input  logic              layer_done,
    input  logic              syndrome_ok,
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     iters_used,
    output logic              shift_err
);

    localparam logic [DATA_W-1:0] NULL_W = {DATA_W{1'b1}};

    sched_state_e      state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [IW-1:0]     used_q, used_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] shift_q;
    // High in the first ISSUE cycle of an entry, when bm_shift holds that entry's ROM word.
    logic              fresh_q;

    logic              raw_null;
    logic              raw_illegal;
    logic [DATA_W-1:0] clean_shift;
    logic              skip;
    logic              accept;

    assign raw_null    = (bm_shift == NULL_W);
    assign raw_illegal = !raw_null && (32'(bm_shift) >= D);
    assign clean_shift = raw_illegal ? NULL_W : bm_shift;

`ifdef SKIP_NULL_EN
    assign skip = (state_q == StIssue) && fresh_q && raw_null;
`else
    assign skip = 1'b0;
`endif

    // Skipped null entries advance the column without a handshake.
    assign accept = (state_q == StIssue) && (skip || out_ready);

    assign bm_addr    = AW'(row_q) * AW'(COLS) + AW'(col_q);
    assign out_valid  = (state_q == StIssue) && !skip;
    assign out_shift  = fresh_q ? clean_shift : shift_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign iters_used = used_q;
    assign shift_err  = err_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        iter_d  = iter_q;
        used_d  = used_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    iter_d  = '0;
                    used_d  = '0;
                    err_d   = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StIssue;
            end
            StIssue: begin
                if (fresh_q && raw_illegal) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    if (col_q == CW'(COLS - 1)) begin
                        col_d   = '0;
                        state_d = StLayerWait;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = StFetch;
                    end
                end
            end
            StLayerWait: begin
                if (layer_done) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = StIterEnd;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = StFetch;
                    end
                end
            end
            StIterEnd: begin
                iter_d = iter_q + IW'(1);
                if (syndrome_ok || (32'(iter_q) + 32'd1 == MAX_ITER)) begin
                    used_d  = iter_q + IW'(1);
                    state_d = StDone;
                end else begin
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            iter_q  <= '0;
            used_q  <= '0;
            err_q   <= 1'b0;
            shift_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            iter_q  <= iter_d;
            used_q  <= used_d;
            err_q   <= err_d;
            fresh_q <= (state_q == StFetch);
            // Capture the ROM word so the command stays stable while out_ready is low.
            if (fresh_q) begin
                shift_q <= clean_shift;
            end
        end
    end

endmodule
